// File: rtl/hazard_ctrl_unit.sv
// Hazard control for the MIPS pipeline: load-use and MUL/DIV stalls,
// EX operand forwarding selects, branch-redirect flush and a saturating
// stall-cycle counter for performance analysis.
module hazard_ctrl_unit #(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned MD_LAT = 32,
  parameter int unsigned PERF_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] rs_iss_i,
  input  logic [REG_AW-1:0] rt_iss_i,
  input  logic [REG_AW-1:0] rs_ex_i,
  input  logic [REG_AW-1:0] rt_ex_i,
  input  logic [REG_AW-1:0] rd_ex_i,
  input  logic              mem_to_reg_ex_i,
  input  logic              reg_wr_ex_i,
  input  logic [REG_AW-1:0] rd_mem_i,
  input  logic              reg_wr_mem_i,
  input  logic [REG_AW-1:0] rd_wb_i,
  input  logic              reg_wr_wb_i,
  input  logic              md_start_ex_i,
  input  logic              md_use_iss_i,
  input  logic              branch_taken_ex_i,
  input  logic              perf_clr_i,
  output logic              stall_fetch_o,
  output logic              stall_iss_o,
  output logic              flush_iss_o,
  output logic              flush_ex_o,
  output logic [1:0]        fwd_p1_o,
  output logic [1:0]        fwd_p2_o,
  output logic              md_busy_o,
  output logic [PERF_W-1:0] stall_cnt_o
);

  localparam int unsigned MD_W = $clog2(MD_LAT);
  localparam logic [MD_W-1:0]   MD_RELOAD = MD_W'(MD_LAT - 1);
  localparam logic [PERF_W-1:0] CNT_MAX   = '1;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

  logic [MD_W-1:0]   r_md_cnt;
  logic [PERF_W-1:0] r_stall_cnt;
  logic              w_md_busy;
  logic              w_lu;
  logic              w_mdh;
  logic              w_stall;
  logic [1:0]        w_fwd_p1;
  logic [1:0]        w_fwd_p2;

  // Register 0 is hardwired, so it never produces a hazard or a forward.
  function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] src,
                                         input logic [REG_AW-1:0] rd_mem,
                                         input logic              wr_mem,
                                         input logic [REG_AW-1:0] rd_wb,
                                         input logic              wr_wb);
    logic [1:0] sel;
    sel = FWD_RF;
    if (src != '0) begin
      if (wr_mem && (rd_mem == src)) begin
        sel = FWD_MEM;
      end else if (wr_wb && (rd_wb == src)) begin
        sel = FWD_WB;
      end
    end
    return sel;
  endfunction

  assign w_md_busy = (r_md_cnt != '0);

  // Hazard detection and redirect arbitration; redirect wins over any stall.
  always_comb begin
    w_lu = 1'b0;
    w_mdh = 1'b0;
    w_stall = 1'b0;
    if (mem_to_reg_ex_i && reg_wr_ex_i && (rd_ex_i != '0) &&
        ((rd_ex_i == rs_iss_i) || (rd_ex_i == rt_iss_i))) begin
      w_lu = 1'b1;
    end
    if (md_use_iss_i && (w_md_busy || md_start_ex_i)) begin
      w_mdh = 1'b1;
    end
    w_stall = (w_lu || w_mdh) && !branch_taken_ex_i;
  end

  // EX operand forwarding selects, MEM stage preferred over WB.
  always_comb begin
    w_fwd_p1 = fwd_sel(rs_ex_i, rd_mem_i, reg_wr_mem_i, rd_wb_i, reg_wr_wb_i);
    w_fwd_p2 = fwd_sel(rt_ex_i, rd_mem_i, reg_wr_mem_i, rd_wb_i, reg_wr_wb_i);
  end

  // MUL/DIV occupancy counter; a start while busy is ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_md_cnt <= '0;
    end else if (md_start_ex_i && !w_md_busy) begin
      r_md_cnt <= MD_RELOAD;
    end else if (w_md_busy) begin
      r_md_cnt <= r_md_cnt - MD_W'(1);
    end
  end

  // Saturating stall-cycle counter; clear beats increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (perf_clr_i) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != CNT_MAX)) begin
      r_stall_cnt <= r_stall_cnt + PERF_W'(1);
    end
  end

  assign stall_fetch_o = w_stall;
  assign stall_iss_o   = w_stall;
  assign flush_ex_o    = w_stall;
  assign flush_iss_o   = branch_taken_ex_i;
  assign fwd_p1_o      = w_fwd_p1;
  assign fwd_p2_o      = w_fwd_p2;
  assign md_busy_o     = w_md_busy;
  assign stall_cnt_o   = r_stall_cnt;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Bench for hazard_ctrl_unit: directed scenarios plus random traffic, all
// checked against a cycle-indexed reference model.
module tb_hazard_ctrl_unit;

  localparam int unsigned AW  = 5;
  localparam int unsigned LAT = 4;
  localparam int unsigned PW  = 4;
  localparam int          CNT_SAT = (1 << PW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] rs_iss, rt_iss, rs_ex, rt_ex, rd_ex, rd_mem, rd_wb;
  logic          mem_to_reg_ex, reg_wr_ex, reg_wr_mem, reg_wr_wb;
  logic          md_start, md_use, br_taken, perf_clr;
  logic          stall_fetch, stall_iss, flush_iss, flush_ex, md_busy;
  logic [1:0]    fwd_p1, fwd_p2;
  logic [PW-1:0] stall_cnt;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: the cycle index, the cycle the current MUL/DIV
  // was accepted, and the stall count as a plain integer.
  int m_cyc   = 0;
  int m_start = -100;
  int m_cnt   = 0;

  hazard_ctrl_unit #(.REG_AW(AW), .MD_LAT(LAT), .PERF_W(PW)) dut (
    .clk(clk), .rst_n(rst_n),
    .rs_iss_i(rs_iss), .rt_iss_i(rt_iss),
    .rs_ex_i(rs_ex), .rt_ex_i(rt_ex), .rd_ex_i(rd_ex),
    .mem_to_reg_ex_i(mem_to_reg_ex), .reg_wr_ex_i(reg_wr_ex),
    .rd_mem_i(rd_mem), .reg_wr_mem_i(reg_wr_mem),
    .rd_wb_i(rd_wb), .reg_wr_wb_i(reg_wr_wb),
    .md_start_ex_i(md_start), .md_use_iss_i(md_use),
    .branch_taken_ex_i(br_taken), .perf_clr_i(perf_clr),
    .stall_fetch_o(stall_fetch), .stall_iss_o(stall_iss),
    .flush_iss_o(flush_iss), .flush_ex_o(flush_ex),
    .fwd_p1_o(fwd_p1), .fwd_p2_o(fwd_p2),
    .md_busy_o(md_busy), .stall_cnt_o(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // The unit is busy during the LAT-1 cycles following an accepted start.
  function automatic bit m_busy();
    return ((m_cyc - m_start) >= 1) && ((m_cyc - m_start) <= int'(LAT) - 1);
  endfunction

  function automatic logic [1:0] m_fwd(input logic [AW-1:0] src);
    if (src != 0 && reg_wr_mem && rd_mem == src) return 2'b10;
    if (src != 0 && reg_wr_wb && rd_wb == src) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit m_stall();
    bit lu, mdh;
    lu  = mem_to_reg_ex && reg_wr_ex && rd_ex != 0 && (rd_ex == rs_iss || rd_ex == rt_iss);
    mdh = md_use && (m_busy() || md_start);
    return (lu || mdh) && !br_taken;
  endfunction

  task automatic idle();
    rs_iss = '0; rt_iss = '0; rs_ex = '0; rt_ex = '0; rd_ex = '0;
    rd_mem = '0; rd_wb = '0;
    mem_to_reg_ex = 1'b0; reg_wr_ex = 1'b0; reg_wr_mem = 1'b0; reg_wr_wb = 1'b0;
    md_start = 1'b0; md_use = 1'b0; br_taken = 1'b0; perf_clr = 1'b0;
  endtask

  task automatic model_reset();
    m_start = -100;
    m_cnt   = 0;
  endtask

  // One clock: compare every output with the model mid-cycle, then advance.
  task automatic cycle();
    bit s;
    int nxt_start, nxt_cnt;
    @(negedge clk);
    s = m_stall();
    chk("stall_fetch", 32'(stall_fetch), 32'(s));
    chk("stall_iss",   32'(stall_iss),   32'(s));
    chk("flush_ex",    32'(flush_ex),    32'(s));
    chk("flush_iss",   32'(flush_iss),   32'(br_taken));
    chk("fwd_p1",      32'(fwd_p1),      32'(m_fwd(rs_ex)));
    chk("fwd_p2",      32'(fwd_p2),      32'(m_fwd(rt_ex)));
    chk("md_busy",     32'(md_busy),     32'(m_busy()));
    chk("stall_cnt",   32'(stall_cnt),   32'(m_cnt));
    nxt_start = (md_start && !m_busy()) ? m_cyc : m_start;
    if (perf_clr)  nxt_cnt = 0;
    else if (s)    nxt_cnt = (m_cnt + 1 > CNT_SAT) ? CNT_SAT : m_cnt + 1;
    else           nxt_cnt = m_cnt;
    @(posedge clk);
    m_cyc++;
    m_start = nxt_start;
    m_cnt   = nxt_cnt;
    #1;
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    #2;
    chk("rst_md_busy",   32'(md_busy),     32'd0);
    chk("rst_stall_cnt", 32'(stall_cnt),   32'd0);
    chk("rst_stall",     32'(stall_fetch), 32'd0);
    chk("rst_fwd_p1",    32'(fwd_p1),      32'd0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    // Load-use on rs, then the same with rd=0.
    mem_to_reg_ex = 1'b1; reg_wr_ex = 1'b1; rd_ex = 5'd5; rs_iss = 5'd5;
    #1 chk("lu_stall", 32'(stall_fetch), 32'd1);
    cycle();
    rd_ex = 5'd0; rs_iss = 5'd0;
    #1 chk("lu_r0", 32'(stall_iss), 32'd0);
    cycle();
    idle();

    // Forwarding priority and register 0.
    reg_wr_mem = 1'b1; rd_mem = 5'd3; reg_wr_wb = 1'b1; rd_wb = 5'd3; rs_ex = 5'd3;
    #1 chk("fwd_mem", 32'(fwd_p1), 32'd2);
    cycle();
    reg_wr_mem = 1'b0;
    #1 chk("fwd_wb", 32'(fwd_p1), 32'd1);
    cycle();
    reg_wr_mem = 1'b1; rd_mem = 5'd0; rt_ex = 5'd0;
    #1 chk("fwd_r0", 32'(fwd_p2), 32'd0);
    cycle();
    idle();

    // MUL/DIV occupancy with the user waiting in ISS, plus a start while busy.
    md_use = 1'b1; md_start = 1'b1;
    cycle();
    md_start = 1'b0;
    for (int i = 0; i < int'(LAT); i++) begin
      if (i == 1) md_start = 1'b1;
      else        md_start = 1'b0;
      #1 chk("md_busy_win", 32'(md_busy), (i < int'(LAT) - 1) ? 32'd1 : 32'd0);
      cycle();
    end
    idle();

    // Redirect beats a simultaneous load-use; start under a branch still loads.
    mem_to_reg_ex = 1'b1; reg_wr_ex = 1'b1; rd_ex = 5'd7; rt_iss = 5'd7;
    br_taken = 1'b1; md_start = 1'b1;
    #1 chk("redir_flush_iss", 32'(flush_iss), 32'd1);
    chk("redir_stall", 32'(stall_fetch), 32'd0);
    chk("redir_flush_ex", 32'(flush_ex), 32'd0);
    cycle();
    idle();
    #1 chk("redir_md_loaded", 32'(md_busy), 32'd1);
    for (int i = 0; i < int'(LAT); i++) cycle();

    // Counter saturation, then a clear while stalling.
    mem_to_reg_ex = 1'b1; reg_wr_ex = 1'b1; rd_ex = 5'd9; rs_iss = 5'd9;
    for (int i = 0; i < 20; i++) cycle();
    chk("cnt_sat", 32'(stall_cnt), 32'(CNT_SAT));
    perf_clr = 1'b1;
    cycle();
    chk("cnt_clr", 32'(stall_cnt), 32'd0);
    perf_clr = 1'b0;
    idle();

    // Asynchronous reset in the middle of an occupancy.
    md_start = 1'b1;
    cycle();
    md_start = 1'b0;
    cycle();
    chk("pre_rst_busy", 32'(md_busy), 32'd1);
    #2 rst_n = 1'b0;
    #1 chk("async_rst_busy", 32'(md_busy), 32'd0);
    model_reset();
    rst_n = 1'b1;
    md_start = 1'b1;
    cycle();
    md_start = 1'b0;
    for (int i = 0; i < int'(LAT); i++) begin
      #1 chk("restart_busy", 32'(md_busy), (i < int'(LAT) - 1) ? 32'd1 : 32'd0);
      cycle();
    end

    // Random traffic over a small register space to provoke matches.
    for (int i = 0; i < 400; i++) begin
      rs_iss = AW'($urandom_range(0, 3));
      rt_iss = AW'($urandom_range(0, 3));
      rs_ex  = AW'($urandom_range(0, 3));
      rt_ex  = AW'($urandom_range(0, 3));
      rd_ex  = AW'($urandom_range(0, 3));
      rd_mem = AW'($urandom_range(0, 3));
      rd_wb  = AW'($urandom_range(0, 3));
      mem_to_reg_ex = 1'($urandom_range(0, 1));
      reg_wr_ex     = 1'($urandom_range(0, 1));
      reg_wr_mem    = 1'($urandom_range(0, 1));
      reg_wr_wb     = 1'($urandom_range(0, 1));
      md_start = ($urandom_range(0, 5) == 0);
      md_use   = ($urandom_range(0, 2) == 0);
      br_taken = ($urandom_range(0, 7) == 0);
      perf_clr = ($urandom_range(0, 29) == 0);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
